// File: rtl/dds_tune_ctrl_if.sv
// Key-request and tuning-word bundle between a tuning key panel and dds_tune_ctrl.
interface dds_tune_ctrl_if;
  logic        Switchadd;
  logic        Switchsub;
  logic        SwitchMicroadd;
  logic        SwitchMicrosub;
  logic        SwitchNanoadd;
  logic        SwitchNanosub;
  logic        Phaseadd;
  logic        Phasesub;
  logic [31:0] FreqWord;
  logic [31:0] PhaseWord;
  logic        Update;

  modport master (
    output Switchadd, Switchsub, SwitchMicroadd, SwitchMicrosub,
    output SwitchNanoadd, SwitchNanosub, Phaseadd, Phasesub,
    input  FreqWord, PhaseWord, Update
  );

  modport slave (
    input  Switchadd, Switchsub, SwitchMicroadd, SwitchMicrosub,
    input  SwitchNanoadd, SwitchNanosub, Phaseadd, Phasesub,
    output FreqWord, PhaseWord, Update
  );
endinterface

// File: rtl/dds_tune_ctrl.sv
// DDS tuning controller: active-low keys step FreqWord/PhaseWord, 3-edge key-to-word latency, one key at a time.
// No backpressure (a step always applies); auto-repeat on held keys when DDS_TUNE_REPEAT_EN is defined.
module dds_tune_ctrl #(
  parameter logic [31:0] FTW_RESET   = 32'd1000,
  parameter logic [31:0] FTW_MAX     = 32'h7FFFFFFF,
  parameter logic [31:0] STEP_COARSE = 32'd1000000,
  parameter logic [31:0] STEP_MICRO  = 32'd1000,
  parameter logic [31:0] STEP_NANO   = 32'd1,
  parameter logic [31:0] PHASE_STEP  = 32'h40000000,
  parameter logic [31:0] HOLD_CYC    = 32'd50000000,
  parameter logic [31:0] REP_CYC     = 32'd5000000
) (
  input logic            clk,
  input logic            reset,
  dds_tune_ctrl_if.slave tune
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1
`ifdef DDS_TUNE_REPEAT_EN
    ,
    WAIT   = 2'd2,
    REPEAT = 2'd3
`endif
  } stateT;

  if (HOLD_CYC == 32'd0 || REP_CYC == 32'd0) begin : gBadRepeatCfg
    $error("dds_tune_ctrl: HOLD_CYC and REP_CYC must be nonzero");
  end

  stateT       state;
  stateT       stateNxt;
  logic [7:0]  reqRaw;
  logic [7:0]  syncA;
  logic [7:0]  syncB;
  logic [7:0]  reqActive;
  logic        anyActive;
  logic        selActive;
  logic [2:0]  prioSel;
  logic [2:0]  reqSel;
  logic [2:0]  selNxt;
  logic [2:0]  stepSel;
  logic        doStep;
  logic [31:0] freqWord;
  logic [31:0] phaseWord;
  logic [31:0] freqNxt;
  logic [31:0] phaseNxt;
  logic        stepChg;
  logic        updPulse;
`ifdef DDS_TUNE_REPEAT_EN
  logic [31:0] repCnt;
  logic [31:0] repCntNxt;
`endif

  // Bit order is the priority order: bit 0 wins.
  assign reqRaw = {tune.Phasesub, tune.Phaseadd, tune.SwitchNanosub, tune.SwitchNanoadd,
                   tune.SwitchMicrosub, tune.SwitchMicroadd, tune.Switchsub, tune.Switchadd};

  assign reqActive = ~syncB;
  assign anyActive = |reqActive;
  assign selActive = reqActive[reqSel];

  always_comb begin
    prioSel = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (reqActive[i]) prioSel = 3'(i);
    end
  end

  function automatic logic [31:0] satAdd(input logic [31:0] a, input logic [31:0] s);
    logic [32:0] sum;
    sum = {1'b0, a} + {1'b0, s};
    if (sum > {1'b0, FTW_MAX}) satAdd = FTW_MAX;
    else                       satAdd = sum[31:0];
  endfunction

  function automatic logic [31:0] satSub(input logic [31:0] a, input logic [31:0] s);
    if (s > a) satSub = 32'd0;
    else       satSub = a - s;
  endfunction

  always_comb begin
    stateNxt = state;
    selNxt   = reqSel;
    doStep   = 1'b0;
`ifdef DDS_TUNE_REPEAT_EN
    repCntNxt = repCnt;
`endif
    case (state)
      IDLE: begin
        if (anyActive) begin
          selNxt = prioSel;
          doStep = 1'b1;
`ifdef DDS_TUNE_REPEAT_EN
          stateNxt  = WAIT;
          repCntNxt = 32'd0;
`else
          stateNxt = ACTIVE;
`endif
        end
      end
      ACTIVE: begin
        if (!selActive) stateNxt = IDLE;
      end
`ifdef DDS_TUNE_REPEAT_EN
      WAIT: begin
        if (!selActive) begin
          stateNxt  = IDLE;
          repCntNxt = 32'd0;
        end else if (repCnt == HOLD_CYC - 32'd1) begin
          stateNxt  = REPEAT;
          repCntNxt = 32'd0;
        end else begin
          repCntNxt = repCnt + 32'd1;
        end
      end
      REPEAT: begin
        if (!selActive) begin
          stateNxt  = IDLE;
          repCntNxt = 32'd0;
        end else if (repCnt == REP_CYC - 32'd1) begin
          doStep    = 1'b1;
          repCntNxt = 32'd0;
        end else begin
          repCntNxt = repCnt + 32'd1;
        end
      end
`endif
      default: stateNxt = IDLE;
    endcase
  end

  assign stepSel = (state == IDLE) ? prioSel : reqSel;

  always_comb begin
    freqNxt  = freqWord;
    phaseNxt = phaseWord;
    if (doStep) begin
      case (stepSel)
        3'd0:    freqNxt  = satAdd(freqWord, STEP_COARSE);
        3'd1:    freqNxt  = satSub(freqWord, STEP_COARSE);
        3'd2:    freqNxt  = satAdd(freqWord, STEP_MICRO);
        3'd3:    freqNxt  = satSub(freqWord, STEP_MICRO);
        3'd4:    freqNxt  = satAdd(freqWord, STEP_NANO);
        3'd5:    freqNxt  = satSub(freqWord, STEP_NANO);
        3'd6:    phaseNxt = phaseWord + PHASE_STEP;
        default: phaseNxt = phaseWord - PHASE_STEP;
      endcase
    end
  end

  // A step that lands on the clamp it already sits at is silent.
  assign stepChg = (freqNxt != freqWord) || (phaseNxt != phaseWord);

  always_ff @(posedge clk) begin
    if (!reset) begin
      syncA     <= 8'hFF;
      syncB     <= 8'hFF;
      state     <= IDLE;
      reqSel    <= 3'd0;
      freqWord  <= FTW_RESET;
      phaseWord <= 32'd0;
      updPulse  <= 1'b0;
`ifdef DDS_TUNE_REPEAT_EN
      repCnt    <= 32'd0;
`endif
    end else begin
      syncA     <= reqRaw;
      syncB     <= syncA;
      state     <= stateNxt;
      reqSel    <= selNxt;
      freqWord  <= freqNxt;
      phaseWord <= phaseNxt;
      updPulse  <= doStep && stepChg;
`ifdef DDS_TUNE_REPEAT_EN
      repCnt    <= repCntNxt;
`endif
    end
  end

  assign tune.FreqWord  = freqWord;
  assign tune.PhaseWord = phaseWord;
  assign tune.Update    = updPulse;

endmodule
